ast_pool: RTL

- Parametrised asteroid object table. Replaces the fixed A_NUM start-up set with a SLOTS-deep pool.
- Holds type, sub-pixel position and velocity per slot.
- Advances every live asteroid once per frame, with screen wrap.
- Splits an asteroid into two smaller ones on a hit. Sits between the collision logic and the asteroid sprite renderer.

---
 rtl/ast_pool_pkg.sv | 38 +++
 rtl/ast_pool_free_enc.sv | 26 ++
 rtl/ast_pool.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ast_pool_pkg.sv
// Shared asteroid-pool types and constants: asteroid size classes, slot layout,
// screen extents and the split size-step helper.
package ast_pool_pkg;

  localparam int XY_FRACTION  = 7;
  localparam int AST_SLOTS    = 16;
  localparam int AST_VW       = 8;
  localparam int AST_SCREEN_W = 640;
  localparam int AST_SCREEN_H = 480;
  localparam int AST_PW       = 10 + XY_FRACTION;

  typedef enum logic [1:0] {
    AST_SMALL  = 2'd0,
    AST_MED    = 2'd1,
    AST_LARGE  = 2'd2,
    AST_XLARGE = 2'd3
  } ast_t;

  typedef struct packed {
    logic                     live;
    ast_t                     ast_type;
    logic [AST_PW-1:0]        x;
    logic [AST_PW-1:0]        y;
    logic signed [AST_VW-1:0] vx;
    logic signed [AST_VW-1:0] vy;
  } ast_slot_t;

  // A split produces children one size class below the parent; SMALL never splits.
  function automatic ast_t ast_next(input ast_t t);
    case (t)
      AST_XLARGE: return AST_LARGE;
      AST_LARGE:  return AST_MED;
      AST_MED:    return AST_SMALL;
      default:    return AST_SMALL;
    endcase
  endfunction

endpackage

// File: rtl/ast_pool_free_enc.sv
// Lowest-index free slot finder for the asteroid pool; found is low when every
// slot is live.
module ast_pool_free_enc #(
  parameter int SLOTS = 16,
  localparam int SW = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] live,
  output logic [SW-1:0]    free_idx,
  output logic             found
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_idx = SW'(i);
        found    = 1'b1;
      end else begin
        found    = found;
      end
    end
  end

endmodule

// File: rtl/ast_pool.sv
// SLOTS-deep asteroid object table: spawn, per-frame move with screen wrap and
// hit splitting. Define AST_POOL_SPEEDUP_EN to make split children 1.25x faster.
module ast_pool
  import ast_pool_pkg::*;
#(
  parameter int SLOTS    = AST_SLOTS,
  parameter int VW       = AST_VW,
  parameter int SCREEN_W = AST_SCREEN_W,
  parameter int SCREEN_H = AST_SCREEN_H,
  localparam int PW = 10 + XY_FRACTION,
  localparam int SW = $clog2(SLOTS),
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  ast_t                 spawn_type,
  input  logic [PW-1:0]        spawn_x,
  input  logic [PW-1:0]        spawn_y,
  input  logic signed [VW-1:0] spawn_vx,
  input  logic signed [VW-1:0] spawn_vy,
  input  logic                 hit_valid,
  output logic                 hit_ready,
  input  logic [SW-1:0]        hit_slot,
  input  logic [SW-1:0]        rd_slot,
  output logic                 rd_live,
  output ast_t                 rd_type,
  output logic [PW-1:0]        rd_x,
  output logic [PW-1:0]        rd_y,
  output logic [CW-1:0]        alive_count,
  output logic                 level_clear,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_SPLIT = 2'd2} state_t;

  localparam logic signed [PW+1:0] EXT_X = (PW+2)'(SCREEN_W * (2 ** XY_FRACTION));
  localparam logic signed [PW+1:0] EXT_Y = (PW+2)'(SCREEN_H * (2 ** XY_FRACTION));
  localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN = {1'b1, {(VW-1){1'b0}}};

  state_t               state_r;
  logic                 tick_pend_r;
  logic [SW-1:0]        idx_r;
  logic [SW-1:0]        hit_slot_r;
  logic [SLOTS-1:0]     live_r;
  ast_t                 type_r [SLOTS];
  logic [PW-1:0]        x_r    [SLOTS];
  logic [PW-1:0]        y_r    [SLOTS];
  logic signed [VW-1:0] vx_r   [SLOTS];
  logic signed [VW-1:0] vy_r   [SLOTS];
  logic [CW-1:0]        count_r;
  logic                 level_clear_r;
  logic                 overflow_r;
  logic                 rd_live_r;
  ast_t                 rd_type_r;
  logic [PW-1:0]        rd_x_r;
  logic [PW-1:0]        rd_y_r;

  logic [SW-1:0]        free_idx_s;
  logic                 free_found_s;
  logic                 idle_s;
  logic                 spawn_fire_s;
  logic                 hit_fire_s;
  logic                 hit_live_s;
  logic                 hit_small_s;
  logic [CW-1:0]        count_next_s;
  logic [PW-1:0]        nx_s;
  logic [PW-1:0]        ny_s;
  logic signed [VW-1:0] a_vx_s, a_vy_s, b_vx_s, b_vy_s;

  // Single-correction wrap: |v| is smaller than the screen extent.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] pos,
                                             input logic signed [VW-1:0] v,
                                             input logic signed [PW+1:0] ext);
    logic signed [PW+1:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{(PW+2-VW){v[VW-1]}}, v});
    if (sum[PW+1]) begin
      sum = sum + ext;
    end else if (sum >= ext) begin
      sum = sum - ext;
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] v);
    if (v == V_MIN) begin
      return V_MAX;
    end else begin
      return -v;
    end
  endfunction

`ifdef AST_POOL_SPEEDUP_EN
  function automatic logic signed [VW-1:0] child_vel(input logic signed [VW-1:0] v);
    logic signed [VW:0] e;
    logic signed [VW-1:0] q;
    q = v >>> 2;
    e = $signed({v[VW-1], v}) + $signed({q[VW-1], q});
    if (e[VW] != e[VW-1]) begin
      return e[VW] ? V_MIN : V_MAX;
    end else begin
      return e[VW-1:0];
    end
  endfunction
`else
  function automatic logic signed [VW-1:0] child_vel(input logic signed [VW-1:0] v);
    return v;
  endfunction
`endif

  ast_pool_free_enc #(.SLOTS(SLOTS)) u_free_enc (
    .live     (live_r),
    .free_idx (free_idx_s),
    .found    (free_found_s)
  );

  // A tick on the wire this cycle outranks hit and spawn, so both readies drop.
  assign idle_s       = (state_r == ST_IDLE) && !tick_pend_r && !frame_tick;
  assign hit_ready    = idle_s;
  assign spawn_ready  = idle_s && !hit_valid && free_found_s;
  assign hit_fire_s   = hit_valid && hit_ready;
  assign spawn_fire_s = spawn_valid && spawn_ready;
  assign hit_live_s   = live_r[hit_slot_r];
  assign hit_small_s  = (type_r[hit_slot_r] == AST_SMALL);

  assign nx_s   = wrap_add(x_r[idx_r], vx_r[idx_r], EXT_X);
  assign ny_s   = wrap_add(y_r[idx_r], vy_r[idx_r], EXT_Y);
  assign a_vx_s = child_vel(vy_r[hit_slot_r]);
  assign a_vy_s = child_vel(neg_sat(vx_r[hit_slot_r]));
  assign b_vx_s = child_vel(neg_sat(vy_r[hit_slot_r]));
  assign b_vy_s = child_vel(vx_r[hit_slot_r]);

  // Live-count delta for this cycle, so the registered count tracks live_r exactly.
  always_comb begin
    count_next_s = count_r;
    if (spawn_fire_s) begin
      count_next_s = count_r + CW'(1);
    end else if ((state_r == ST_SPLIT) && hit_live_s) begin
      if (hit_small_s) begin
        count_next_s = count_r - CW'(1);
      end else if (free_found_s) begin
        count_next_s = count_r + CW'(1);
      end else begin
        count_next_s = count_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Control FSM, slot table, counters and the registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      tick_pend_r   <= 1'b0;
      idx_r         <= '0;
      hit_slot_r    <= '0;
      live_r        <= '0;
      count_r       <= '0;
      level_clear_r <= 1'b0;
      overflow_r    <= 1'b0;
      rd_live_r     <= 1'b0;
      rd_type_r     <= AST_SMALL;
      rd_x_r        <= '0;
      rd_y_r        <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        type_r[i] <= AST_SMALL;
        x_r[i]    <= '0;
        y_r[i]    <= '0;
        vx_r[i]   <= '0;
        vy_r[i]   <= '0;
      end
    end else begin
      tick_pend_r   <= tick_pend_r | frame_tick;
      count_r       <= count_next_s;
      level_clear_r <= (count_r != '0) && (count_next_s == '0);
      rd_live_r     <= live_r[rd_slot];
      rd_type_r     <= type_r[rd_slot];
      rd_x_r        <= x_r[rd_slot];
      rd_y_r        <= y_r[rd_slot];
      case (state_r)
        ST_IDLE: begin
          if (tick_pend_r || frame_tick) begin
            state_r     <= ST_MOVE;
            idx_r       <= '0;
            tick_pend_r <= 1'b0;
          end else if (hit_fire_s) begin
            hit_slot_r <= hit_slot;
            state_r    <= ST_SPLIT;
          end else if (spawn_fire_s) begin
            live_r[free_idx_s] <= 1'b1;
            type_r[free_idx_s] <= spawn_type;
            x_r[free_idx_s]    <= spawn_x;
            y_r[free_idx_s]    <= spawn_y;
            vx_r[free_idx_s]   <= spawn_vx;
            vy_r[free_idx_s]   <= spawn_vy;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MOVE: begin
          if (live_r[idx_r]) begin
            x_r[idx_r] <= nx_s;
            y_r[idx_r] <= ny_s;
          end
          if (idx_r == SW'(SLOTS - 1)) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
          end else begin
            idx_r <= idx_r + SW'(1);
          end
        end
        ST_SPLIT: begin
          if (hit_live_s) begin
            if (hit_small_s) begin
              live_r[hit_slot_r] <= 1'b0;
            end else begin
              type_r[hit_slot_r] <= ast_next(type_r[hit_slot_r]);
              vx_r[hit_slot_r]   <= a_vx_s;
              vy_r[hit_slot_r]   <= a_vy_s;
              if (free_found_s) begin
                live_r[free_idx_s] <= 1'b1;
                type_r[free_idx_s] <= ast_next(type_r[hit_slot_r]);
                x_r[free_idx_s]    <= x_r[hit_slot_r];
                y_r[free_idx_s]    <= y_r[hit_slot_r];
                vx_r[free_idx_s]   <= b_vx_s;
                vy_r[free_idx_s]   <= b_vy_s;
              end else begin
                overflow_r <= 1'b1;
              end
            end
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_live     = rd_live_r;
  assign rd_type     = rd_type_r;
  assign rd_x        = rd_x_r;
  assign rd_y        = rd_y_r;
  assign alive_count = count_r;
  assign level_clear = level_clear_r;
  assign overflow    = overflow_r;
  assign busy        = (state_r != ST_IDLE);

endmodule
